// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl: memory-mapped platform interrupt controller.
//
// Collects NSRC asynchronous interrupt sources and synchronizes them. Each
// source passes through a level or rising-edge gateway into PENDING. A
// claim/complete register pair lets software service one source at a time.
// The controller drives the machine external interrupt line (meip) to the
// core.
//
// Source i carries ID i+1. ID 0 means "no source".
//
// Register map (byte offsets; only bus_addr[4:2] is decoded):
//   0x00 PENDING    RO
//   0x04 ENABLE     RW
//   0x08 EDGE_MODE  RW  (1 = rising edge, 0 = level)
//   0x0C CLAIM      read: claim lowest eligible ID; write: complete ID
//   0x10 INFLIGHT   RO
//   Unmapped reads return 0. Unmapped writes are ignored.
//
// Ports:
//   clk        core clock
//   rstn       synchronous active-low reset
//   irq_src    raw asynchronous interrupt requests, active high
//   bus_req    register access strobe, one access per cycle
//   bus_wr     1 = write, 0 = read (qualified by bus_req)
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_rdata  registered read data, one-cycle latency, held between reads
//   meip       registered machine external interrupt pending
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] irq_src,
  input  logic            bus_req,
  input  logic            bus_wr,
  input  logic [11:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            meip
);

  typedef enum logic [2:0] {
    REG_PENDING  = 3'd0,
    REG_ENABLE   = 3'd1,
    REG_EDGE     = 3'd2,
    REG_CLAIM    = 3'd3,
    REG_INFLIGHT = 3'd4
  } reg_sel_e;

  // State
  logic [NSRC-1:0] r_sync [SYNC_STAGES];
  logic [NSRC-1:0] r_prev;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_enable;
  logic [NSRC-1:0] r_edge;
  logic [NSRC-1:0] r_inflight;

  // Decode
  reg_sel_e        w_sel;
  logic            w_rd;
  logic            w_wr;
  logic            w_claim_rd;
  logic            w_cmpl_wr;
  logic            w_unused_addr;

  // Gateway and claim/complete
  logic [NSRC-1:0] w_s;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_set_edge;
  logic [NSRC-1:0] w_set_level;
  logic [NSRC-1:0] w_claim_oh;
  logic [NSRC-1:0] w_claim_clr;
  logic [NSRC-1:0] w_cmpl_oh;
  logic [NSRC-1:0] w_pending_nxt;
  logic [NSRC-1:0] w_inflight_nxt;
  logic [4:0]      w_claim_id;
  logic [31:0]     w_rdata_nxt;

  assign w_sel      = reg_sel_e'(bus_addr[4:2]);
  assign w_rd       = bus_req & ~bus_wr;
  assign w_wr       = bus_req &  bus_wr;
  assign w_claim_rd = w_rd & (w_sel == REG_CLAIM);
  assign w_cmpl_wr  = w_wr & (w_sel == REG_CLAIM);

  // Address bits outside [4:2] are intentionally ignored (registers alias).
  assign w_unused_addr = ^{bus_addr[11:5], bus_addr[1:0]};

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_elig = r_pending & r_enable & ~r_inflight;

  // Edge gateway records a rising edge even while the source is in flight.
  // Level gateway stays closed while the source is in flight.
  assign w_set_edge  =  r_edge & w_s & ~r_prev;
  assign w_set_level = ~r_edge & w_s & ~r_inflight;

  // Lowest-index eligible source wins the claim.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_claim_id = '0;
    w_claim_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_claim_id    = 5'(i + 1);
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
      end
    end
  end

  // A claim that returns 0 has an all-zero one-hot and so changes nothing.
  assign w_claim_clr = w_claim_rd ? w_claim_oh : '0;

  // Complete decodes the full 32-bit ID; out-of-range values match nothing.
  always_comb begin
    w_cmpl_oh = '0;
    if (w_cmpl_wr) begin
      for (int i = 0; i < NSRC; i++) begin
        if (bus_wdata == 32'(i + 1)) w_cmpl_oh[i] = 1'b1;
      end
    end
  end

  // Same-cycle claim and set: an edge set survives the claim, a level set
  // does not (the gateway closes as the source goes in flight).
  assign w_pending_nxt  = (r_pending & ~w_claim_clr) | w_set_edge
                        | (w_set_level & ~w_claim_clr);
  assign w_inflight_nxt = (r_inflight | w_claim_clr) & ~w_cmpl_oh;

  always_comb begin
    w_rdata_nxt = '0;
    case (w_sel)
      REG_PENDING:  w_rdata_nxt = 32'(r_pending);
      REG_ENABLE:   w_rdata_nxt = 32'(r_enable);
      REG_EDGE:     w_rdata_nxt = 32'(r_edge);
      REG_CLAIM:    w_rdata_nxt = 32'(w_claim_id);
      REG_INFLIGHT: w_rdata_nxt = 32'(r_inflight);
      default:      w_rdata_nxt = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev     <= '0;
      r_pending  <= '0;
      r_enable   <= '0;
      r_edge     <= '0;
      r_inflight <= '0;
      bus_rdata  <= '0;
      meip       <= 1'b0;
    end else begin
      r_sync[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev     <= w_s;
      r_pending  <= w_pending_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_wr && (w_sel == REG_ENABLE)) r_enable <= bus_wdata[NSRC-1:0];
      if (w_wr && (w_sel == REG_EDGE))   r_edge   <= bus_wdata[NSRC-1:0];
      if (w_rd) bus_rdata <= w_rdata_nxt;
      meip <= |w_elig;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (NSRC=8,
// SYNC_STAGES=2). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int NSRC = 8;

  localparam logic [11:0] A_PEND  = 12'h000;
  localparam logic [11:0] A_EN    = 12'h004;
  localparam logic [11:0] A_EDGE  = 12'h008;
  localparam logic [11:0] A_CLAIM = 12'h00C;
  localparam logic [11:0] A_INFL  = 12'h010;
  localparam logic [11:0] A_UNMAP = 12'h014;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSRC-1:0] irq_src;
  logic            bus_req;
  logic            bus_wr;
  logic [11:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic            meip;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .irq_src  (irq_src),
    .bus_req  (bus_req),
    .bus_wr   (bus_wr),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .meip     (meip)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_req = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    bus_req = 1'b1; bus_wr = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_req = 1'b0;
    d = bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rstn = 1'b0; irq_src = '0; bus_req = 1'b0; bus_wr = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    tick(2);
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h exp 0", bus_rdata); end
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL reset_meip got %0b exp 0", meip); end
    rstn = 1'b1;
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending got %0h exp 0", d); end
    bus_read(A_EN, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got %0h exp 0", d); end
  endtask

  task automatic test_level_claim();
    logic [31:0] d;
    bus_write(A_EN, 32'h01);
    bus_write(A_EDGE, 32'h00);
    irq_src = 8'h01;
    tick(3);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL lvl_meip_early got %0b exp 0", meip); end
    tick(1);
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL lvl_meip_latency got %0b exp 1", meip); end
    bus_read(A_CLAIM, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL lvl_claim got %0h exp 1", d); end
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL lvl_inflight got %0h exp 1", d); end
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL lvl_meip_drop got %0b exp 0", meip); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lvl_pending_inflight got %0h exp 0", d); end
  endtask

  task automatic test_complete_rearm();
    logic [31:0] d;
    bus_write(A_CLAIM, 32'h1);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL rearm_meip_c0 got %0b exp 0", meip); end
    tick(1);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL rearm_meip_c1 got %0b exp 0", meip); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL rearm_pending got %0h exp 1", d); end
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL rearm_meip got %0b exp 1", meip); end
    bus_read(A_CLAIM, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rearm_claim got %0h exp 1", d); end
    irq_src = '0;
    tick(3);
    bus_write(A_CLAIM, 32'h1);
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rearm_cleanup got %0h exp 0", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    logic [31:0] exp_ids [3];
    exp_ids[0] = 32'h2; exp_ids[1] = 32'h4; exp_ids[2] = 32'h0;
    bus_write(A_EN, 32'h0A);
    irq_src = 8'h0A;
    tick(4);
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL prio_meip got %0b exp 1", meip); end
    for (int k = 0; k < 3; k++) begin
      bus_read(A_CLAIM, d);
      checks++; if (d !== exp_ids[k]) begin errors++; $display("FAIL prio_claim%0d got %0h exp %0h", k, d, exp_ids[k]); end
    end
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL prio_inflight got %0h exp a", d); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio_pending got %0h exp 0", d); end
    irq_src = '0;
    tick(3);
    bus_write(A_CLAIM, 32'h2);
    bus_write(A_CLAIM, 32'h4);
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL prio_cleanup got %0h exp 0", d); end
  endtask

  task automatic test_edge_mode();
    logic [31:0] d;
    bus_write(A_EDGE, 32'h04);
    bus_write(A_EN, 32'h04);
    irq_src = 8'h04; tick(3); irq_src = '0; tick(4);
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL edge_meip got %0b exp 1", meip); end
    bus_read(A_CLAIM, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL edge_claim got %0h exp 3", d); end
    tick(1);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_meip_claimed got %0b exp 0", meip); end
    irq_src = 8'h04; tick(3); irq_src = '0; tick(4);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL edge_repend got %0h exp 4", d); end
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_meip_inflight got %0b exp 0", meip); end
    bus_write(A_CLAIM, 32'h3);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL edge_meip_c0 got %0b exp 0", meip); end
    tick(1);
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL edge_meip_c1 got %0b exp 1", meip); end
    bus_read(A_CLAIM, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL edge_claim2 got %0h exp 3", d); end
  endtask

  task automatic test_bad_access();
    logic [31:0] d;
    logic [31:0] bad_ids [3];
    bad_ids[0] = 32'h0; bad_ids[1] = 32'h9; bad_ids[2] = 32'h5;
    for (int k = 0; k < 3; k++) begin
      bus_write(A_CLAIM, bad_ids[k]);
      bus_read(A_INFL, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL bad_cmpl_%0h got %0h exp 4", bad_ids[k], d); end
    end
    bus_read(A_UNMAP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmap_read got %0h exp 0", d); end
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    bus_read(A_EN, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL unmap_enable got %0h exp 4", d); end
    bus_read(A_EDGE, d);
    checks++; if (d !== 32'h04) begin errors++; $display("FAIL unmap_edge got %0h exp 4", d); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmap_pending got %0h exp 0", d); end
    bus_write(A_CLAIM, 32'h3);
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL bad_cleanup got %0h exp 0", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d;
    bus_write(A_EDGE, 32'hFF);
    bus_write(A_EN, 32'hFF);
    irq_src = 8'hFF; tick(4);
    irq_src = '0;
    bus_read(A_CLAIM, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL midop_claim got %0h exp 1", d); end
    tick(3);
    irq_src = 8'h01; tick(4);
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL midop_inflight got %0h exp 1", d); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL midop_pending got %0h exp ff", d); end
    checks++; if (meip !== 1'b1) begin errors++; $display("FAIL midop_meip got %0b exp 1", meip); end
    rstn = 1'b0;
    tick(1);
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL midop_rst_meip got %0b exp 0", meip); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL midop_rst_rdata got %0h exp 0", bus_rdata); end
    rstn = 1'b1; irq_src = '0;
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midop_rst_pending got %0h exp 0", d); end
    bus_read(A_EN, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midop_rst_enable got %0h exp 0", d); end
    bus_read(A_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midop_rst_edge got %0h exp 0", d); end
    bus_read(A_INFL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midop_rst_inflight got %0h exp 0", d); end
    checks++; if (meip !== 1'b0) begin errors++; $display("FAIL midop_rst_meip2 got %0b exp 0", meip); end
  endtask

  initial begin
    test_reset();
    test_level_claim();
    test_complete_rearm();
    test_priority();
    test_edge_mode();
    test_bad_access();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
